// File: rtl/usart_rx.sv
// usart_rx: 8N1 oversampling serial receiver feeding a first-word-fall-through FIFO.
// Build option: define USART_RX_PARITY_EN for an even-parity (8E1) frame and a parity_error_o flag.
// Ports:
//   clk_i           system clock, all logic on the rising edge
//   reset_i         synchronous active-high reset
//   rx_pin_i        asynchronous serial input, idle high
//   read_i          pop FIFO head this cycle (ignored when empty)
//   clear_errors_i  one-cycle pulse clearing the sticky error flags
//   data_out_o      FIFO head byte, valid while data_ready_o=1
//   data_ready_o    FIFO not empty
//   frame_error_o   sticky: stop bit sampled low
//   overrun_o       sticky: byte received while FIFO full and not being read
//   parity_error_o  sticky: parity mismatch (USART_RX_PARITY_EN only)
module usart_rx #(
    parameter int CLOCK_DIV  = 139,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_pin_i,
    input  logic       read_i,
    input  logic       clear_errors_i,
    output logic [7:0] data_out_o,
    output logic       data_ready_o,
    output logic       frame_error_o,
`ifdef USART_RX_PARITY_EN
    output logic       parity_error_o,
`endif
    output logic       overrun_o
);
    localparam int CW = $clog2(CLOCK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLOCK_DIV - 1);
    localparam logic [PW:0]   DEPTH   = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef USART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_e;

    logic          meta_q, rx_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          commit, frame_set;
    logic          frame_q, ovr_q;
`ifdef USART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d, par_set, par_q;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   fill_q;
    logic          pop, full, push, ovr_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        frame_set = 1'b0;
`ifdef USART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            START: if (cnt_q == HALF_M1) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
`ifdef USART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            // LSB arrives first, so shifting right leaves bit 0 at the bottom after 8 samples.
            DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                shift_d = {rx_s_q, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7)
`ifdef USART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
            end
`ifdef USART_RX_PARITY_EN
            PARITY: if (cnt_q == FULL_M1) begin
                cnt_d     = '0;
                par_bad_d = (^shift_q) != rx_s_q;
                par_set   = par_bad_d;
                state_d   = STOP;
            end
`endif
            STOP: if (cnt_q == FULL_M1) begin
                cnt_d     = '0;
                state_d   = rx_s_q ? IDLE : BRK;
                frame_set = !rx_s_q;
`ifdef USART_RX_PARITY_EN
                commit    = rx_s_q && !par_bad_q;
`else
                commit    = rx_s_q;
`endif
            end
            // A line held low reports one frame error, then waits for idle.
            BRK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pop          = read_i && fill_q != '0;
    assign full         = fill_q == DEPTH;
    // When full, a same-cycle read frees the head slot, so the write still fits.
    assign push         = commit && (!full || pop);
    assign ovr_set      = commit && full && !pop;
    assign data_ready_o = fill_q != '0;
    assign data_out_o   = data_ready_o ? mem_q[rd_q] : 8'h00;
    assign frame_error_o = frame_q;
    assign overrun_o     = ovr_q;
`ifdef USART_RX_PARITY_EN
    assign parity_error_o = par_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fill_q    <= '0;
            frame_q   <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef USART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            meta_q    <= rx_pin_i;
            rx_s_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wr_q      <= wr_q + PW'(push);
            rd_q      <= rd_q + PW'(pop);
            fill_q    <= fill_q + (PW+1)'(push) - (PW+1)'(pop);
            // A new error event outranks a coincident clear.
            frame_q   <= frame_set || (frame_q && !clear_errors_i);
            ovr_q     <= ovr_set || (ovr_q && !clear_errors_i);
`ifdef USART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            par_q     <= par_set || (par_q && !clear_errors_i);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= shift_q;
    end
endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed plus randomized bench for usart_rx, checked against a queue-based receiver model.
`timescale 1ns/1ps
module tb_usart_rx;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
`ifdef USART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rd = 1'b0, clr = 1'b0;
    logic [7:0] dout;
    logic       rdy, fe, ov;
`ifdef USART_RX_PARITY_EN
    logic       pe;
`endif
    int         checks = 0, failures = 0;
    logic [7:0] mq[$];
    logic       exp_fe = 1'b0, exp_ov = 1'b0, exp_pe = 1'b0;
    int         cyc = 0, rise_cyc = -1, fall_cyc = 0;
    logic       prev_rdy = 1'b0;

    usart_rx #(.CLOCK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .rx_pin_i(rx),
        .read_i(rd),
        .clear_errors_i(clr),
        .data_out_o(dout),
        .data_ready_o(rdy),
        .frame_error_o(fe),
`ifdef USART_RX_PARITY_EN
        .parity_error_o(pe),
`endif
        .overrun_o(ov)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rdy && !prev_rdy) rise_cyc = cyc;
        prev_rdy = rdy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_error"}, {31'd0, fe}, {31'd0, exp_fe});
        check({tag, "_overrun"}, {31'd0, ov}, {31'd0, exp_ov});
`ifdef USART_RX_PARITY_EN
        check({tag, "_parity_error"}, {31'd0, pe}, {31'd0, exp_pe});
`endif
    endtask

    // Receiver model: a committed byte pops first (if read that cycle) then pushes or overruns.
    function automatic void model_commit(input logic [7:0] d, input logic popped);
        if (popped && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(d);
        else exp_ov = 1'b1;
    endfunction

    // pulse: 0 none, 1 read, 2 clear_errors -- asserted for exactly the stop-bit sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int pulse);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(DIV);
        end
`ifdef USART_RX_PARITY_EN
        rx = par_b;
        tick(DIV);
`endif
        rx = stop_b;
        tick(DIV / 2 + 2);
        if (pulse == 1) begin
            check("head_at_commit", {24'd0, dout}, {24'd0, mq[0]});
            rd = 1'b1;
        end
        if (pulse == 2) clr = 1'b1;
        tick(1);
        rd  = 1'b0;
        clr = 1'b0;
        tick(DIV - DIV / 2 - 3);
        if (PB != 0 && par_b != ^d) exp_pe = 1'b1;
        if (!stop_b) exp_fe = 1'b1;
        else if (PB == 0 || par_b == ^d) model_commit(d, pulse == 1);
    endtask

    task automatic send_ok(input logic [7:0] d, input int pulse);
        send_frame(d, 1'b1, ^d, pulse);
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
            check({tag, "_data"}, {24'd0, dout}, {24'd0, mq.pop_front()});
            rd = 1'b1;
            tick(1);
            rd = 1'b0;
        end
        check({tag, "_empty"}, {31'd0, rdy}, 32'd0);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        exp_pe = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int n;
        tick(3);
        reset = 1'b0;
        check("reset_ready", {31'd0, rdy}, 32'd0);
        check("reset_data", {24'd0, dout}, 32'd0);
        check_flags("reset");
        tick(2);

        fall_cyc = cyc;
        send_ok(8'hA5, 0);
        check("latency", rise_cyc - fall_cyc, 2 + DIV / 2 + (9 + PB) * DIV + 1);
        drain("a5");
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        check("read_empty", {31'd0, rdy}, 32'd0);

        send_ok(8'h00, 0);
        send_ok(8'hFF, 0);
        send_ok(8'h3C, 0);
        drain("b2b");
        check_flags("b2b");

        for (int i = 1; i <= 5; i++) send_ok(8'(i), 0);
        check_flags("ovr");
        drain("ovr");
        pulse_clear();
        check_flags("ovr_clr");

        for (int i = 1; i <= 4; i++) send_ok(8'(i), 0);
        send_ok(8'h05, 1);
        check_flags("popush");
        drain("popush");

        for (int i = 1; i <= 4; i++) send_ok(8'(i), 0);
        send_ok(8'h05, 2);
        check_flags("event_wins");
        for (int i = 0; i < 2; i++) begin
            check("pre_reset_data", {24'd0, dout}, {24'd0, mq.pop_front()});
            rd = 1'b1;
            tick(1);
            rd = 1'b0;
        end
        rx = 1'b0;
        tick(DIV);
        rx = 1'b1;
        tick(3 * DIV);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mq.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        exp_pe = 1'b0;
        check("midreset_ready", {31'd0, rdy}, 32'd0);
        check("midreset_data", {24'd0, dout}, 32'd0);
        check_flags("midreset");
        tick(2 * DIV);
        send_ok(8'hC3, 0);
        drain("c3");

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * DIV);
        check("glitch_ready", {31'd0, rdy}, 32'd0);
        check_flags("glitch");

        send_frame(8'h96, 1'b0, ^8'h96, 0);
        tick(40);
        check_flags("break");
        check("break_ready", {31'd0, rdy}, 32'd0);
        rx = 1'b1;
        tick(2 * DIV);
        send_ok(8'h5A, 0);
        drain("5a");
        pulse_clear();
        check_flags("fe_clr");

        send_frame(8'h00, 1'b0, 1'b0, 0);
        tick(10);
        pulse_clear();
        tick(30);
        rx = 1'b1;
        tick(2 * DIV);
        check_flags("single_break");
        check("single_break_ready", {31'd0, rdy}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_ok(b, 0);
                tick(int'($urandom_range(0, 3)) * DIV);
            end
            check_flags("rand");
            drain("rand");
            pulse_clear();
        end

`ifdef USART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        drain("par_ok");
        check_flags("par_ok");
        send_frame(8'h07, 1'b1, 1'b0, 0);
        check_flags("par_bad");
        check("par_bad_ready", {31'd0, rdy}, 32'd0);
        pulse_clear();
        check_flags("par_clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Serial receive counterpart to the existing transmit-side usart_ctrl: 8N1 asynchronous receiver on the board's USART RX pin.
- Clocked from the 16 MHz system clock.
- Oversamples the line, assembles bytes and buffers them in a small first-word-fall-through FIFO.
- Bus-side logic drains the FIFO with a single-cycle read strobe.

Parameters:
- CLOCK_DIV, 139, system clocks per bit (16 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- rx_pin  input  1  asynchronous serial input, idle high
- read  input  1  pop FIFO head this cycle; ignored when empty
- clear_errors  input  1  one-cycle pulse, clears sticky error flags
- data_out  output  8  FIFO head byte, valid while data_ready=1
- data_ready  output  1  FIFO not empty
- frame_error  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte received while FIFO full and not being read

Behaviour:
- Reset values:
  - data_ready=0, frame_error=0, overrun=0, data_out=8'h00 (don't-care while empty, but driven 0 after reset).
  - FIFO pointers/count cleared, FSM=IDLE, synchronizer flops=1.
- Reset mid-frame or with FIFO contents: partial byte and all buffered bytes discarded.
- rx_pin passes a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Bit counter counts 0..CLOCK_DIV-1. Bit index counts 0..7 and is LSB first.
- FSM:
  - IDLE: on rx_s=0, load counter, go START.
  - START: wait CLOCK_DIV/2 (integer division) clocks, then sample. If rx_s=1, treat as a glitch: go IDLE with no flags. If rx_s=0, go DATA with bit index 0.
  - DATA: every CLOCK_DIV clocks, sample rx_s into the shift register at the bit index. After bit 7, go STOP.
  - STOP: after CLOCK_DIV clocks, sample.
    - rx_s=1: commit byte to FIFO, go IDLE.
    - rx_s=0: discard byte, set frame_error, go BREAK.
  - BREAK: stay until rx_s=1, then go IDLE. A held-low line yields exactly one frame_error event, not repeated frames.
- Commit timing:
  - Byte is written on the clock edge of the stop-bit sample.
  - data_ready and data_out are valid the following cycle.
  - rx_pin-to-data_ready latency is 2 sync cycles + CLOCK_DIV/2 + 9*CLOCK_DIV + 1 clocks after the start edge.
- FIFO:
  - data_out is combinational from the head entry.
  - read with data_ready=1 advances the head next edge.
  - Pointers wrap modulo FIFO_DEPTH. An explicit count (width clog2(FIFO_DEPTH)+1) distinguishes full from empty.
- Boundary rules:
  - Commit while full and read=0: new byte dropped, existing contents unchanged, overrun set.
  - Commit and read in the same cycle: pop then push; count unchanged; no overrun, including when full.
  - Commit and read in the same cycle with the FIFO empty: impossible, since read is ignored when empty; byte is pushed.
  - read while empty: no effect, no underflow.
- Error flags:
  - Sticky until clear_errors or reset.
  - If clear_errors coincides with a new error event, the flag remains set (event wins).
- IDLE re-arms the same cycle it is entered, so back-to-back frames with a single stop bit are received without loss.

Optional Feature:
- Macro: USART_RX_PARITY_EN.
- Defined:
  - FSM inserts a PARITY state between DATA and STOP, sampled after CLOCK_DIV clocks. Even parity over the 8 data bits.
  - Adds output parity_error (1 bit, sticky, reset 0, cleared by clear_errors).
  - Mismatch: byte discarded, parity_error set; the stop bit is still checked before returning to IDLE.
  - Frame length is 11 bit times.
- Not defined: no PARITY state, no parity_error port; the 8N1 behaviour above is unchanged.

Test Plan:
- CLOCK_DIV=8. Send 8'hA5, 8N1 → data_ready rises exactly 2+4+72+1 clocks after the start falling edge; data_out=8'hA5; read pulse → data_ready=0.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap, no reads → FIFO holds 3 entries; reads return 00, FF, 3C in order; no error flags.
- FIFO_DEPTH=4. Send 5 bytes 8'h01..8'h05 with no reads → overrun=1; reads return 01..04 only. Repeat with read pulsed on the 5th commit cycle → overrun=0 and 05 is retained.
- Drive rx_pin low for 3 clocks (shorter than CLOCK_DIV/2) → FSM returns to IDLE; data_ready=0; no flags. Then drive a frame with stop bit 0 and hold low 40 clocks → frame_error=1, nothing pushed; after line high, send 8'h5A → received correctly; clear_errors → frame_error=0.
- Assert reset mid-DATA with 2 bytes buffered → next cycle data_ready=0, all flags 0. Subsequent frame 8'hC3 is received intact.
- With USART_RX_PARITY_EN: send 8'h07 with parity bit 1 → accepted. Send 8'h07 with parity bit 0 → parity_error=1, FIFO empty.
